// File: rtl/eth_frame_filter_mc.sv
// Captures the first FRM_BYTES of each MAC frame and filters on dest MAC/EtherType into a tagged FIFO; 2 cycles from last beat to pkt_valid_o.
// The MAC side is never stalled; a passing frame that finds the FIFO full is dropped and flagged on overflow_o.
module eth_frame_filter_mc #(
  parameter int DATA_BYTES = 4,
  parameter int FRM_BYTES  = 42,
  parameter int N_CH       = 2,
  parameter int DEPTH      = 2,
  parameter int BCAST_EN   = 1,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [47:0]             hw_addr_i,
  input  logic [16*N_CH-1:0]      ethertype_i,
  input  logic [N_CH-1:0]         ch_en_i,
  input  logic [8*DATA_BYTES-1:0] mac_data_i,
  input  logic [DATA_BYTES-1:0]   mac_keep_i,
  input  logic                    mac_valid_i,
  input  logic                    mac_last_i,
  output logic [8*FRM_BYTES-1:0]  pkt_o,
  output logic [CH_W-1:0]         pkt_ch_o,
  output logic                    pkt_valid_o,
  input  logic                    pkt_ready_i,
  output logic [15:0]             cnt_ok_o,
  output logic [15:0]             cnt_drop_o,
  output logic                    overflow_o
);
  localparam int CW = $clog2(FRM_BYTES + DATA_BYTES + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, CHECK = 2'd2} state_t;

  state_t                 state, state_nxt;
  logic [7:0]             frm [FRM_BYTES];
  logic [8*FRM_BYTES-1:0] frm_vec;
  logic [CW-1:0]          byte_cnt, base, beat_n, sum;
  logic                   start, dest_ok, hit, room, pop;
  logic                   enq, drop_chk, drop_short, ovf_nxt;
  logic [CH_W-1:0]        hit_ch;
  logic [47:0]            dest;
  logic [15:0]            etype;
  logic [1:0]             drop_inc;
  logic [16:0]            drop_sum;

  logic                   pend_vld;
  logic [8*FRM_BYTES-1:0] pend_dat;
  logic [CH_W-1:0]        pend_ch;
  logic [8*FRM_BYTES-1:0] mem_dat [DEPTH];
  logic [CH_W-1:0]        mem_ch  [DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [OW-1:0]          fifo_cnt;

  function automatic logic [CW-1:0] popcnt(input logic [DATA_BYTES-1:0] k);
    logic [CW-1:0] n;
    n = '0;
    for (int j = 0; j < DATA_BYTES; j++) n = n + {{(CW-1){1'b0}}, k[j]};
    return n;
  endfunction

  // Any beat outside CAPTURE opens a new frame at offset 0.
  assign start  = (state != CAPTURE);
  assign base   = start ? '0 : byte_cnt;
  assign beat_n = popcnt(mac_keep_i);
  assign sum    = base + beat_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FRM_BYTES; i++) frm[i] <= '0;
    end else if (mac_valid_i) begin
      for (int i = 0; i < FRM_BYTES; i++) begin
        if (start) frm[i] <= '0;
        for (int j = 0; j < DATA_BYTES; j++)
          if (mac_keep_i[j] && (int'(base) + j == i)) frm[i] <= mac_data_i[8*j +: 8];
      end
    end
  end

  always_comb begin
    frm_vec = '0;
    for (int i = 0; i < FRM_BYTES; i++) frm_vec[8*(FRM_BYTES-1-i) +: 8] = frm[i];
  end

  assign dest    = frm_vec[8*FRM_BYTES-1 -: 48];
  assign etype   = frm_vec[8*FRM_BYTES-97 -: 16];
  assign dest_ok = (dest == hw_addr_i) || ((BCAST_EN != 0) && (&dest));

  // Descending scan so the lowest matching channel wins.
  always_comb begin
    hit    = 1'b0;
    hit_ch = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (ch_en_i[k] && (ethertype_i[16*k +: 16] == etype)) begin
        hit    = 1'b1;
        hit_ch = CH_W'(k);
      end
    end
  end

  // Occupancy includes the frame waiting in the pending stage.
  assign pop  = pkt_valid_o && pkt_ready_i;
  assign room = (int'(fifo_cnt) + int'(pend_vld) - int'(pop)) < DEPTH;

  always_comb begin
    state_nxt  = state;
    enq        = 1'b0;
    drop_chk   = 1'b0;
    drop_short = 1'b0;
    ovf_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (mac_valid_i) begin
          state_nxt  = mac_last_i ? IDLE : CAPTURE;
          drop_short = mac_last_i;
        end
      end
      CAPTURE: begin
        if (mac_valid_i && mac_last_i) begin
          if (sum >= CW'(FRM_BYTES)) state_nxt = CHECK;
          else begin
            state_nxt  = IDLE;
            drop_short = 1'b1;
          end
        end
      end
      CHECK: begin
        enq      = dest_ok && hit && room;
        drop_chk = !(dest_ok && hit && room);
        ovf_nxt  = dest_ok && hit && !room;
        state_nxt = IDLE;
        if (mac_valid_i) begin
          state_nxt  = mac_last_i ? IDLE : CAPTURE;
          drop_short = mac_last_i;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign drop_inc = {1'b0, drop_chk} + {1'b0, drop_short};
  assign drop_sum = {1'b0, cnt_drop_o} + {15'd0, drop_inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      pend_vld   <= 1'b0;
      pend_dat   <= '0;
      pend_ch    <= '0;
      overflow_o <= 1'b0;
      cnt_ok_o   <= '0;
      cnt_drop_o <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      if (mac_valid_i) byte_cnt <= (sum > CW'(FRM_BYTES)) ? CW'(FRM_BYTES) : sum;
      pend_vld   <= enq;
      if (enq) begin
        pend_dat <= frm_vec;
        pend_ch  <= hit_ch;
      end
      overflow_o <= ovf_nxt;
      if (enq && cnt_ok_o != 16'hFFFF) cnt_ok_o <= cnt_ok_o + 16'd1;
      cnt_drop_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (pend_vld) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)      rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      fifo_cnt   <= fifo_cnt + OW'(pend_vld) - OW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (pend_vld) begin
      mem_dat[wr_ptr] <= pend_dat;
      mem_ch[wr_ptr]  <= pend_ch;
    end
  end

  assign pkt_valid_o = (fifo_cnt != '0);
  assign pkt_o       = pkt_valid_o ? mem_dat[rd_ptr] : '0;
  assign pkt_ch_o    = pkt_valid_o ? mem_ch[rd_ptr]  : '0;
endmodule

// File: tb/tb_eth_frame_filter_mc.sv
// Directed-vector bench for eth_frame_filter_mc with a queue scoreboard and a decoupled output monitor.
module tb_eth_frame_filter_mc;
  localparam int DB  = 4;
  localparam int FB  = 42;
  localparam int NCH = 2;
  localparam int DEP = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [47:0]     hw_addr_i;
  logic [16*NCH-1:0] ethertype_i;
  logic [NCH-1:0]  ch_en_i;
  logic [8*DB-1:0] mac_data_i;
  logic [DB-1:0]   mac_keep_i;
  logic            mac_valid_i;
  logic            mac_last_i;
  logic [8*FB-1:0] pkt_o;
  logic [0:0]      pkt_ch_o;
  logic            pkt_valid_o;
  logic            pkt_ready_i;
  logic [15:0]     cnt_ok_o;
  logic [15:0]     cnt_drop_o;
  logic            overflow_o;

  eth_frame_filter_mc #(.DATA_BYTES(DB), .FRM_BYTES(FB), .N_CH(NCH), .DEPTH(DEP), .BCAST_EN(1)) dut (
    .clk(clk), .rst(rst), .hw_addr_i(hw_addr_i), .ethertype_i(ethertype_i), .ch_en_i(ch_en_i),
    .mac_data_i(mac_data_i), .mac_keep_i(mac_keep_i), .mac_valid_i(mac_valid_i), .mac_last_i(mac_last_i),
    .pkt_o(pkt_o), .pkt_ch_o(pkt_ch_o), .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i),
    .cnt_ok_o(cnt_ok_o), .cnt_drop_o(cnt_drop_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8*FB-1:0] pkt;
    logic [0:0]      ch;
  } exp_t;

  localparam logic [47:0] OWN   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] fb[$];
  int         checks = 0;
  int         errors = 0;
  int         ovf_cnt = 0;
  int         ovf_base;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic check_pkt(input string name, input logic [8*FB-1:0] act, input logic [8*FB-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Frame = dst | fixed src | ethertype | payload bytes (seed + index).
  task automatic make_frame(input logic [47:0] dst, input logic [15:0] et, input int len, input logic [7:0] seed);
    logic [47:0] src;
    src = 48'h0A_0B_0C_0D_0E_0F;
    fb.delete();
    for (int i = 0; i < 6; i++) fb.push_back(dst[8*(5-i) +: 8]);
    for (int i = 0; i < 6; i++) fb.push_back(src[8*(5-i) +: 8]);
    fb.push_back(et[15:8]);
    fb.push_back(et[7:0]);
    for (int i = 14; i < len; i++) fb.push_back(seed + 8'(i));
  endtask

  function automatic logic [8*FB-1:0] exp_vec();
    logic [8*FB-1:0] v;
    v = '0;
    for (int i = 0; i < FB; i++) v[8*(FB-1-i) +: 8] = fb[i];
    return v;
  endfunction

  task automatic expect_pkt(input logic [0:0] ch);
    exp_t e;
    e.pkt = exp_vec();
    e.ch  = ch;
    exp_q.push_back(e);
  endtask

  // Called just after a clock edge; returns just after the edge that sampled the final beat sent.
  task automatic send(input int max_beats);
    int nb;
    nb = 0;
    for (int b = 0; b < fb.size() && nb < max_beats; b += DB) begin
      mac_data_i = '0;
      mac_keep_i = '0;
      for (int j = 0; j < DB; j++) begin
        if (b + j < fb.size()) begin
          mac_data_i[8*j +: 8] = fb[b+j];
          mac_keep_i[j]        = 1'b1;
        end
      end
      mac_valid_i = 1'b1;
      mac_last_i  = (b + DB >= fb.size());
      nb++;
      @(posedge clk); #1;
    end
    mac_valid_i = 1'b0;
    mac_last_i  = 1'b0;
    mac_keep_i  = '0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && overflow_o) ovf_cnt++;
    if (!rst && pkt_valid_o && pkt_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pkt: got packet on ch %0d, required none", pkt_ch_o);
      end else begin
        mon_e = exp_q.pop_front();
        check_pkt("mon_pkt", pkt_o, mon_e.pkt);
        check("mon_ch", 64'(pkt_ch_o), 64'(mon_e.ch));
      end
    end
  end

  initial begin
    rst         = 1'b1;
    hw_addr_i   = OWN;
    ethertype_i = {16'h0800, 16'h0806};
    ch_en_i     = 2'b11;
    mac_data_i  = '0;
    mac_keep_i  = '0;
    mac_valid_i = 1'b0;
    mac_last_i  = 1'b0;
    pkt_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_valid", 64'(pkt_valid_o), 64'd0);
    check_pkt("rst_pkt", pkt_o, '0);
    check("rst_ch", 64'(pkt_ch_o), 64'd0);
    check("rst_ok", 64'(cnt_ok_o), 64'd0);
    check("rst_drop", 64'(cnt_drop_o), 64'd0);
    check("rst_ovf", 64'(overflow_o), 64'd0);
    @(posedge clk); #1;

    // ARP broadcast, 60 bytes, latency check
    make_frame(BCAST, 16'h0806, 60, 8'h10);
    expect_pkt(1'b0);
    send(100);
    @(negedge clk); check("lat_check_cycle", 64'(pkt_valid_o), 64'd0);
    @(negedge clk); check("lat_pend_cycle", 64'(pkt_valid_o), 64'd0);
    check("arp_ok", 64'(cnt_ok_o), 64'd1);
    @(negedge clk); check("lat_valid", 64'(pkt_valid_o), 64'd1);
    check("arp_dest", 64'(pkt_o[335:288]), 64'hFFFF_FFFF_FFFF);
    check("arp_etype", 64'(pkt_o[239:224]), 64'h0806);
    check("arp_ch", 64'(pkt_ch_o), 64'd0);
    @(posedge clk); #1;
    wait_drain("arp_drain");

    // IPv4 unicast, 42 bytes, partial last beat
    make_frame(OWN, 16'h0800, 42, 8'h40);
    expect_pkt(1'b1);
    send(100);
    wait_drain("ipv4_drain");
    check("ipv4_ok", 64'(cnt_ok_o), 64'd2);

    make_frame(OTHER, 16'h0800, 42, 8'h40);
    send(100);
    idle(5);
    check("miss_drop", 64'(cnt_drop_o), 64'd1);
    check("miss_ok", 64'(cnt_ok_o), 64'd2);

    make_frame(OWN, 16'h0800, 20, 8'h55);
    send(100);
    idle(5);
    check("short_drop", 64'(cnt_drop_o), 64'd2);

    // Back-to-back: second frame starts in the CHECK cycle
    make_frame(BCAST, 16'h0806, 60, 8'h60);
    expect_pkt(1'b0);
    send(100);
    make_frame(OWN, 16'h0800, 42, 8'h70);
    expect_pkt(1'b1);
    send(100);
    wait_drain("b2b_drain");
    check("b2b_ok", 64'(cnt_ok_o), 64'd4);

    // Overflow with consumer stalled
    pkt_ready_i = 1'b0;
    ovf_base = ovf_cnt;
    for (int f = 0; f < 3; f++) begin
      make_frame(BCAST, 16'h0806, 60, 8'h80 + 8'(16*f));
      if (f < 2) expect_pkt(1'b0);
      send(100);
      idle(3);
    end
    idle(3);
    check("ovf_pulses", 64'(ovf_cnt - ovf_base), 64'd1);
    check("ovf_drop", 64'(cnt_drop_o), 64'd3);
    check("ovf_ok", 64'(cnt_ok_o), 64'd6);
    @(negedge clk);
    check("hold_valid", 64'(pkt_valid_o), 64'd1);
    check_pkt("hold_head", pkt_o, exp_q[0].pkt);
    idle(2);
    @(negedge clk);
    check_pkt("hold_head_later", pkt_o, exp_q[0].pkt);
    @(posedge clk); #1;
    pkt_ready_i = 1'b1;
    @(negedge clk); check("pop1_valid", 64'(pkt_valid_o), 64'd1);
    @(negedge clk); check("pop2_valid", 64'(pkt_valid_o), 64'd1);
    @(negedge clk); check("pop_empty", 64'(pkt_valid_o), 64'd0);
    check("pop_q_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;

    // Channel enable and priority
    ch_en_i = 2'b01;
    make_frame(OWN, 16'h0800, 42, 8'hA0);
    send(100);
    idle(5);
    check("chen_drop", 64'(cnt_drop_o), 64'd4);
    ch_en_i     = 2'b11;
    ethertype_i = {16'h0806, 16'h0806};
    make_frame(OWN, 16'h0806, 42, 8'hB0);
    expect_pkt(1'b0);
    send(100);
    wait_drain("prio_drain");
    check("prio_ok", 64'(cnt_ok_o), 64'd7);
    ethertype_i = {16'h0800, 16'h0806};

    // Reset in the middle of a frame
    make_frame(OWN, 16'h0800, 60, 8'hC0);
    send(8);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_ok", 64'(cnt_ok_o), 64'd0);
    check("mrst_drop", 64'(cnt_drop_o), 64'd0);
    check("mrst_valid", 64'(pkt_valid_o), 64'd0);
    check_pkt("mrst_pkt", pkt_o, '0);
    check("mrst_ovf", 64'(overflow_o), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    make_frame(OWN, 16'h0800, 60, 8'hD0);
    expect_pkt(1'b1);
    send(100);
    wait_drain("post_rst_drain");
    check("post_rst_ok", 64'(cnt_ok_o), 64'd1);
    check("post_rst_drop", 64'(cnt_drop_o), 64'd0);

    // Saturate the drop counter with single-beat runts
    mac_data_i  = '0;
    mac_keep_i  = '1;
    mac_valid_i = 1'b1;
    mac_last_i  = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    mac_valid_i = 1'b0;
    mac_last_i  = 1'b0;
    mac_keep_i  = '0;
    idle(3);
    check("sat_drop", 64'(cnt_drop_o), 64'hFFFF);
    check("sat_ok", 64'(cnt_ok_o), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/eth_frame_filter_mc.md
Name: eth_frame_filter_mc

Overview:
- Multi-channel, multi-byte-lane successor of the single-protocol byte parser.
- Captures the first FRM_BYTES bytes of each frame from a DATA_BYTES-wide MAC stream.
- Filters each frame on destination MAC and on EtherType against N_CH programmable channels.
- Queues accepted frames, tagged with their channel index, in a DEPTH-entry FIFO with valid/ready output; keeps saturating accept/drop statistics.

Parameters:
- DATA_BYTES, 4, bytes per MAC beat, 1..8; lane 0 is the earliest byte.
- FRM_BYTES, 42, bytes captured per frame, >= 14; covers Ethernet header plus protocol payload.
- N_CH, 2, number of EtherType match channels, 1..8.
- DEPTH, 2, output FIFO entries, >= 1.
- BCAST_EN, 1, when 1, dest FF:FF:FF:FF:FF:FF is also accepted.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- hw_addr_i  in  48  own MAC address.
- ethertype_i  in  16*N_CH  channel k EtherType at [16k+15:16k].
- ch_en_i  in  N_CH  per-channel enable.
- mac_data_i  in  8*DATA_BYTES  lane j at [8j+7:8j].
- mac_keep_i  in  DATA_BYTES  lane-valid mask; contiguous from lane 0; only the last beat may be partial.
- mac_valid_i  in  1  beat valid; no backpressure toward the MAC.
- mac_last_i  in  1  final beat of frame.
- pkt_o  out  8*FRM_BYTES  captured frame; byte 0 at [8*FRM_BYTES-1 -: 8].
- pkt_ch_o  out  max(1,$clog2(N_CH))  matching channel index.
- pkt_valid_o  out  1  FIFO head valid.
- pkt_ready_i  in  1  consumer ready.
- cnt_ok_o  out  16  frames enqueued, saturating.
- cnt_drop_o  out  16  frames dropped (short, filter miss, overflow), saturating.
- overflow_o  out  1  one-cycle pulse when a passing frame is dropped because the FIFO is full.

Behaviour:
- Reset: all outputs 0, FIFO empty, counters 0, FSM in IDLE. Reset mid-frame discards the partial frame. The first valid beat after reset release is treated as the first beat of a frame.
- Frame byte map: dest MAC bytes 0-5, src MAC bytes 6-11, EtherType bytes 12-13 (big-endian).
- FSM states IDLE, CAPTURE, CHECK.
- IDLE:
  - On a valid beat, store its kept bytes at byte offset 0 and set byte count to popcount(keep).
  - Go to CAPTURE.
  - If mac_last_i is set on that beat, the frame is short: cnt_drop +1, stay in IDLE, clear the buffer.
- CAPTURE:
  - Each valid beat stores kept bytes at offsets count..count+n-1; bytes at offset >= FRM_BYTES are discarded.
  - Count saturates at FRM_BYTES.
  - Gaps (mac_valid_i low) are allowed and hold state.
  - On a last beat: if total bytes < FRM_BYTES, cnt_drop +1 and go to IDLE; else go to CHECK.
- CHECK (one cycle):
  - dest_ok = (dest == hw_addr_i) or (BCAST_EN and dest all-ones).
  - Channel = lowest k with ch_en_i[k] set and EtherType == ethertype_i[k].
  - Pass = dest_ok and a channel found.
  - Pass with FIFO not full: enqueue {frame, ch}, cnt_ok +1.
  - Pass with FIFO full: drop, cnt_drop +1, overflow_o = 1 the next cycle.
  - Miss: cnt_drop +1.
  - Buffer cleared. A valid beat present during CHECK is accepted as the first beat of the next frame (IDLE rules apply), so back-to-back frames are lossless.
- Latency: last beat sampled at edge N -> CHECK during cycle N..N+1 -> pkt_valid_o high after edge N+2 when the FIFO was empty.
- FIFO:
  - Registered head outputs; pop when pkt_valid_o and pkt_ready_i.
  - Simultaneous push and pop when full: the pop frees the entry and the push succeeds.
  - pkt_o/pkt_ch_o hold stable while pkt_valid_o is high and pkt_ready_i is low.
  - When empty, pkt_valid_o = 0 and pkt_o = 0.
- Counters stick at 0xFFFF. ethertype_i, ch_en_i and hw_addr_i are sampled only in CHECK.

Test Plan:
- Setup: DATA_BYTES=4, FRM_BYTES=42, N_CH=2, ethertype 0x0806/0x0800, ch_en=2'b11, hw_addr 02:00:00:00:00:01.
- 60-byte ARP broadcast (15 full beats) -> pkt_valid_o 2 cycles after last, pkt_ch_o=0, pkt_o[335:288]=48'hFFFFFFFFFFFF, pkt_o[239:224]=16'h0806, cnt_ok_o=1.
- 42-byte IPv4 unicast to 02:00:00:00:00:01, last beat keep=4'b0011 -> pkt_ch_o=1, all 42 bytes exact. Same frame to 02:00:00:00:00:02 -> no valid, cnt_drop_o +1.
- 20-byte frame (last on beat 5) -> no CHECK, no valid, cnt_drop_o +1. A 60-byte frame back-to-back with the following frame's first beat in the CHECK cycle -> both frames enqueued.
- pkt_ready_i=0, three passing frames -> first two held in order, third dropped, overflow_o single pulse, cnt_drop_o +1. Then pkt_ready_i=1 -> two pops on consecutive cycles, pkt_valid_o falls after the second.
- ch_en_i=2'b01 with an 0x0800 frame -> dropped. ethertype_i both 0x0806 -> pkt_ch_o=0.
- rst pulse after 8 beats of a frame -> all outputs 0. The next complete 60-byte frame is accepted with correct content; force 70000 drops -> cnt_drop_o holds 0xFFFF.
